// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit:
// state encoding, opcode/funct constants, mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF,
        S_ID,
        S_EXR,
        S_WBR,
        S_EXI,
        S_WBI,
        S_MA,
        S_MR,
        S_WBM,
        S_MW,
        S_BR,
        S_J,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_RS    = 2'b01;
    localparam logic [1:0] SA_SHAMT = 2'b10;

    localparam logic [1:0] SB_RT     = 2'b00;
    localparam logic [1:0] SB_FOUR   = 2'b01;
    localparam logic [1:0] SB_IMM    = 2'b10;
    localparam logic [1:0] SB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_OPCODE = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
    } ctrl_t;

    // Instruction class dispatch taken out of S_ID.
    function automatic state_t decode_state(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        state_t s;
        s = S_TRAP;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_JR || fn == FN_JALR) s = S_J;
                else                              s = S_EXR;
            end
            OP_J, OP_JAL:   s = S_J;
            OP_BEQ, OP_BNE: s = S_BR;
            OP_LW, OP_SW:   s = S_MA;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_LUI: s = S_EXI;
            default:        s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Per-state control decode for the multicycle unit.
// Pure combinational; reset forces every control to 0.
module mc_outdec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ok,
    input  logic       reset,
    output ctrl_t      ctrl
);

    logic is_shift;
    logic is_rtype;
    logic is_jal;
    logic is_jalr;

    // Instruction-type flags used by the state decode.
    always_comb begin
        is_rtype = (op_code == OP_RTYPE);
        is_shift = is_rtype && (funct == FN_SLL ||
                                funct == FN_SRL ||
                                funct == FN_SRA);
        is_jal   = (op_code == OP_JAL);
        is_jalr  = is_rtype && (funct == FN_JALR);
    end

    // Control outputs from the registered state.
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = SA_PC;
                ctrl.alu_src_b = SB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.ir_write  = mem_ok;
                ctrl.pc_write  = mem_ok;
            end
            S_ID: begin
                ctrl.alu_src_a = SA_PC;
                ctrl.alu_src_b = SB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EXR: begin
                ctrl.alu_src_a = is_shift ? SA_SHAMT : SA_RS;
                ctrl.alu_src_b = SB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_WBR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RD;
                ctrl.mem_to_reg = WD_ALUOUT;
                ctrl.retire     = 1'b1;
            end
            S_EXI: begin
                ctrl.alu_src_a = SA_RS;
                ctrl.alu_src_b = SB_IMM;
                ctrl.alu_op    = ALU_OPCODE;
            end
            S_WBI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = WD_ALUOUT;
                ctrl.retire     = 1'b1;
            end
            S_MA: begin
                ctrl.alu_src_a = SA_RS;
                ctrl.alu_src_b = SB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MR: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_WBM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = WD_MDR;
                ctrl.retire     = 1'b1;
            end
            S_MW: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.retire    = mem_ok;
            end
            S_BR: begin
                ctrl.alu_src_a = SA_RS;
                ctrl.alu_src_b = SB_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_ALUOUT;
                ctrl.pc_write  = (op_code == OP_BEQ) ? zero : ~zero;
                ctrl.retire    = 1'b1;
            end
            S_J: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = is_rtype ? PC_RS : PC_JUMP;
                ctrl.retire    = 1'b1;
                // PC already holds PC+4, so it is the link value.
                if (is_jal) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RA;
                    ctrl.mem_to_reg = WD_PC;
                end else if (is_jalr) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RD;
                    ctrl.mem_to_reg = WD_PC;
                end
            end
            S_TRAP: ctrl = '0;
            default: ctrl = '0;
        endcase
        if (reset) ctrl = '0;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: state register,
// next-state logic, retire counter and illegal flag.
module multicycle_control
    import mc_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1,
    parameter int RET_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtOp,
    output logic             LuOp,
    output logic             Retire,
    output logic [RET_W-1:0] RetireCount,
    output logic             Illegal
);

    localparam logic [RET_W-1:0] RET_MAX = '1;

    state_t           state_q;
    state_t           state_n;
    ctrl_t            ctrl;
    logic             mem_ok;
    logic [RET_W-1:0] ret_cnt_q;
    logic             illegal_q;

    assign mem_ok = MEM_WAIT ? mem_ready : 1'b1;

    // Next state; memory states hold until the access completes.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IF:   if (mem_ok) state_n = S_ID;
            S_ID:   state_n = decode_state(OpCode, Funct);
            S_EXR:  state_n = S_WBR;
            S_EXI:  state_n = S_WBI;
            S_MA:   state_n = (OpCode == OP_LW) ? S_MR : S_MW;
            S_MR:   if (mem_ok) state_n = S_WBM;
            S_MW:   if (mem_ok) state_n = S_IF;
            S_WBR, S_WBI, S_WBM,
            S_BR, S_J: state_n = S_IF;
            S_TRAP: state_n = S_TRAP;
            default: state_n = S_IF;
        endcase
    end

    // State register; reset wins over any pending wait.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_n;
    end

    // Saturating count of retired instructions.
    always_ff @(posedge clk) begin
        if (reset)
            ret_cnt_q <= '0;
        else if (ctrl.retire && ret_cnt_q != RET_MAX)
            ret_cnt_q <= ret_cnt_q + 1'b1;
    end

    // Sticky illegal flag, raised on entry to the trap state.
    always_ff @(posedge clk) begin
        if (reset)                  illegal_q <= 1'b0;
        else if (state_n == S_TRAP) illegal_q <= 1'b1;
    end

    mc_outdec u_outdec (
        .state   (state_q),
        .op_code (OpCode),
        .funct   (Funct),
        .zero    (Zero),
        .mem_ok  (mem_ok),
        .reset   (reset),
        .ctrl    (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign Retire      = ctrl.retire;
    assign RetireCount = ret_cnt_q;
    assign Illegal     = illegal_q;

    // andi zero-extends; every other immediate is sign-extended.
    assign ExtOp = (OpCode != OP_ANDI);
    assign LuOp  = (OpCode == OP_LUI);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control:
// per-cycle expected controls queued by the driver.
module tb_multicycle_control;

    localparam int P_IF   = 0;
    localparam int P_ID   = 1;
    localparam int P_EXR  = 2;
    localparam int P_WBR  = 3;
    localparam int P_EXI  = 4;
    localparam int P_WBI  = 5;
    localparam int P_MA   = 6;
    localparam int P_MR   = 7;
    localparam int P_WBM  = 8;
    localparam int P_MW   = 9;
    localparam int P_BR   = 10;
    localparam int P_J    = 11;
    localparam int P_TRAP = 12;
    localparam int P_RST  = 13;

    typedef struct packed {
        logic       pcw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rgw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] pcs;
        logic       ret;
        logic       ill;
        logic       ext;
        logic       lu;
    } ctl_t;

    typedef struct {
        ctl_t v;
        ctl_t m;
        int   ph;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OpCode = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IorD, MemRead, MemWrite;
    logic       IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       ExtOp, LuOp, Retire, Illegal;
    logic [2:0] RetireCount;

    ctl_t obs;
    sb_t  sb[$];
    logic [2:0] ret_m = 3'd0;
    int n_chk = 0;
    int n_pass = 0;

    multicycle_control #(
        .MEM_WAIT (1'b1),
        .RET_W    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .ExtOp       (ExtOp),
        .LuOp        (LuOp),
        .Retire      (Retire),
        .RetireCount (RetireCount),
        .Illegal     (Illegal)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, IorD, MemRead, MemWrite,
                  IRWrite, RegWrite, RegDst, MemtoReg,
                  ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  Retire, Illegal, ExtOp, LuOp};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    function automatic string pname(input int ph);
        string n[14] = '{"IF", "ID", "EXR", "WBR", "EXI",
                         "WBI", "MA", "MR", "WBM", "MW",
                         "BR", "J", "TRAP", "RST"};
        return n[ph];
    endfunction

    // Reference controls for one cycle of a given phase.
    function automatic ctl_t model(input int ph,
                                   input logic [5:0] op,
                                   input logic [5:0] fn,
                                   input logic z,
                                   input logic rdy);
        ctl_t c;
        c = '0;
        c.ext = (op != 6'h0c);
        c.lu  = (op == 6'h0f);
        case (ph)
            P_IF: begin
                c.mrd = 1'b1; c.asb = 2'b01;
                c.pcw = rdy;  c.irw = rdy;
            end
            P_ID: c.asb = 2'b11;
            P_EXR: begin
                c.asa = (op == 6'h00 && (fn == 6'h00 ||
                         fn == 6'h02 || fn == 6'h03))
                        ? 2'b10 : 2'b01;
                c.aop = 2'b10;
            end
            P_WBR: begin
                c.rgw = 1'b1; c.rdst = 2'b01; c.ret = 1'b1;
            end
            P_EXI: begin
                c.asa = 2'b01; c.asb = 2'b10; c.aop = 2'b11;
            end
            P_WBI: begin
                c.rgw = 1'b1; c.ret = 1'b1;
            end
            P_MA: begin
                c.asa = 2'b01; c.asb = 2'b10;
            end
            P_MR: begin
                c.mrd = 1'b1; c.iord = 1'b1;
            end
            P_WBM: begin
                c.rgw = 1'b1; c.m2r = 2'b01; c.ret = 1'b1;
            end
            P_MW: begin
                c.mwr = 1'b1; c.iord = 1'b1; c.ret = rdy;
            end
            P_BR: begin
                c.asa = 2'b01; c.aop = 2'b01; c.pcs = 2'b01;
                c.pcw = (op == 6'h04) ? z : ~z;
                c.ret = 1'b1;
            end
            P_J: begin
                c.pcw = 1'b1; c.ret = 1'b1;
                c.pcs = (op == 6'h00) ? 2'b11 : 2'b10;
                if (op == 6'h03) begin
                    c.rgw = 1'b1; c.rdst = 2'b10; c.m2r = 2'b10;
                end
                if (op == 6'h00 && fn == 6'h09) begin
                    c.rgw = 1'b1; c.rdst = 2'b01; c.m2r = 2'b10;
                end
            end
            P_TRAP: c.ill = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Compare each cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t e;
            e = sb.pop_front();
            chk($sformatf("%s@%0t", pname(e.ph), $time),
                32'(obs & e.m), 32'(e.v & e.m));
        end
    end

    task automatic step(input int ph, input logic rdy);
        sb_t e;
        mem_ready = rdy;
        e.v  = model(ph, OpCode, Funct, Zero, rdy);
        e.m  = '1;
        e.ph = ph;
        sb.push_back(e);
        if (e.v.ret)
            ret_m = (ret_m == 3'd7) ? 3'd7 : ret_m + 3'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step();
        sb_t e;
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        e.v   = '0;
        e.m   = '0;
        e.m.pcw = 1'b1; e.m.mrd = 1'b1; e.m.mwr = 1'b1;
        e.m.irw = 1'b1; e.m.rgw = 1'b1; e.m.ret = 1'b1;
        e.ph  = P_RST;
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ret_m = 3'd0;
        chk("rst_cnt", 32'(RetireCount), 32'd0);
        chk("rst_ill", 32'(Illegal), 32'd0);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op,
                             input logic [5:0] fn,
                             input logic z,
                             input int ifw,
                             input int mw);
        OpCode = op;
        Funct  = fn;
        Zero   = z;
        repeat (ifw) step(P_IF, 1'b0);
        step(P_IF, 1'b1);
        step(P_ID, rnd());
        if ((op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) ||
            op == 6'h02 || op == 6'h03) begin
            step(P_J, rnd());
        end else if (op == 6'h00) begin
            step(P_EXR, rnd());
            step(P_WBR, rnd());
        end else if (op == 6'h04 || op == 6'h05) begin
            step(P_BR, rnd());
        end else if (op == 6'h23 || op == 6'h2b) begin
            step(P_MA, rnd());
            repeat (mw) step(op == 6'h23 ? P_MR : P_MW, 1'b0);
            step(op == 6'h23 ? P_MR : P_MW, 1'b1);
            if (op == 6'h23) step(P_WBM, rnd());
        end else if (op inside {6'h08, 6'h09, 6'h0a,
                                6'h0b, 6'h0c, 6'h0f}) begin
            step(P_EXI, rnd());
            step(P_WBI, rnd());
        end else begin
            repeat (4) step(P_TRAP, rnd());
        end
        chk($sformatf("cnt_op%0h", op),
            32'(RetireCount), 32'(ret_m));
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst_step();
        rst_step();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h00, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h03, 1'b1, 1, 0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);
        run_instr(6'h0f, 6'h11, 1'b0, 2, 0);
        run_instr(6'h0c, 6'h00, 1'b1, 0, 0);
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
        run_instr(6'h2b, 6'h00, 1'b0, 0, 1);
        run_instr(6'h2b, 6'h00, 1'b0, 0, 0);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0);
        run_instr(6'h00, 6'h09, 1'b0, 0, 0);
        // reset while a load is waiting on memory
        OpCode = 6'h23;
        Funct  = 6'h00;
        step(P_IF, 1'b1);
        step(P_ID, 1'b1);
        step(P_MA, 1'b0);
        step(P_MR, 1'b0);
        step(P_MR, 1'b0);
        rst_step();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        // undecodable opcode traps until reset
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
        chk("ill_sticky", 32'(Illegal), 32'd1);
        rst_step();
        run_instr(6'h00, 6'h22, 1'b0, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
